// File: rtl/tinyalu_arbiter_if.sv
// Requester-side bundle for the TinyALU round-robin arbiter.
// master = requester layer, slave = arbiter.
interface tinyalu_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [3*NUM_REQ-1:0] req_op;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [15:0]          rsp_result;
  logic                 rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter sharing one TinyALU among NUM_REQ requesters.
// Optional BUSY watchdog enabled by macro TINYALU_ARB_TIMEOUT_EN.
module tinyalu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  tinyalu_arbiter_if.slave bus,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [15:0]      alu_result
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [IW-1:0]      rr;
  logic [IW-1:0]      g;
  logic [IW-1:0]      gnt;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [NUM_REQ-1:0] g_oh;
  logic [7:0]         sel_a;
  logic [7:0]         sel_b;
  logic [2:0]         sel_op;

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
      $error("tinyalu_arbiter: NUM_REQ must be 2..8, TIMEOUT >= 1");
    end
  endgenerate

`ifdef TINYALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`endif

  // First set bit at or above p, wrapping around
  function automatic logic [IW-1:0] rr_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [IW-1:0]      p
  );
    logic [IW-1:0] r;
    logic          hit;
    int            k;
    r   = p;
    hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(p) + i) % NUM_REQ;
      if (!hit && v[k]) begin
        r   = IW'(k);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  assign gnt    = rr_pick(bus.req_valid, rr);
  assign gnt_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt;
  assign g_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << g;
  assign sel_a  = bus.req_a[8*gnt +: 8];
  assign sel_b  = bus.req_b[8*gnt +: 8];
  assign sel_op = bus.req_op[3*gnt +: 3];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      rr             <= '0;
      g              <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= '0;
      alu_start      <= 1'b0;
      bus.req_ready  <= '0;
      bus.rsp_valid  <= '0;
      bus.rsp_result <= '0;
      bus.rsp_err    <= 1'b0;
`ifdef TINYALU_ARB_TIMEOUT_EN
      cnt            <= '0;
`endif
    end else begin
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            g             <= gnt;
            bus.req_ready <= gnt_oh;
            if (sel_op > 3'b100) begin
              bus.rsp_valid  <= gnt_oh;
              bus.rsp_result <= '0;
              bus.rsp_err    <= 1'b1;
              state          <= RESP;
            end else begin
              alu_a     <= sel_a;
              alu_b     <= sel_b;
              alu_op    <= sel_op;
              alu_start <= 1'b1;
`ifdef TINYALU_ARB_TIMEOUT_EN
              cnt       <= '0;
`endif
              state     <= BUSY;
            end
          end
        end
        BUSY: begin
          // no_op finishes after a single start cycle
          if (alu_op == 3'b000 || alu_done) begin
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= '0;
            alu_start      <= 1'b0;
            bus.rsp_valid  <= g_oh;
            bus.rsp_result <= (alu_op == 3'b000) ? 16'h0000 : alu_result;
            bus.rsp_err    <= 1'b0;
            state          <= RESP;
          end
`ifdef TINYALU_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= '0;
            alu_start      <= 1'b0;
            bus.rsp_valid  <= g_oh;
            bus.rsp_result <= 16'h0000;
            bus.rsp_err    <= 1'b1;
            state          <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        RESP: begin
          bus.rsp_result <= '0;
          bus.rsp_err    <= 1'b0;
          rr    <= (g == IW'(NUM_REQ - 1)) ? '0 : g + IW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
